dpram_seq_ctrl: RTL and testbench



---
 rtl/dpram_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_dpram_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_seq_ctrl.sv
// Write/read sequencer for the 27x24 LDPC dual-port RAM: loads a frame of rows, then replays it with a cyclic start offset.
// Optional build macro DPRAM_SEQ_CTRL_PASS_CNT_EN adds a saturating count of completed read passes on pass_cnt.
module dpram_seq_ctrl #(
    parameter int DW    = 24,
    parameter int AW    = 5,
    parameter int DEPTH = 27
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          frame_clr,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_offset,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          rd_done,
    output logic          rd_err,
    output logic          loaded,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    output logic [7:0]    pass_cnt
);

    // Both streams: a beat moves on a clock edge where valid and ready are
    // both high; valid and data are held unchanged until that edge.

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = DEPTH_W - 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WSTRB,
        RSETUP,
        RSTRB,
        RCAP,
        ROUT
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] rd_off_q, rd_off_d;
    logic          in_ready_q, in_ready_d;
    logic          loaded_q, loaded_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          rd_done_q, rd_done_d;
    logic          rd_err_q, rd_err_d;
    logic [AW-1:0] ram_waddr_q, ram_waddr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_raddr_q, ram_raddr_d;
    logic          ram_re_q, ram_re_d;
    logic          offset_ok;

    // Circulant address: base and step are both below DEPTH, so a single
    // conditional subtract brings the sum back into range.
    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base,
                                                input logic [AW-1:0] step);
        logic [AW:0] sum;
        logic [AW:0] red;
        sum = {1'b0, base} + {1'b0, step};
        red = (sum >= DEPTH_W) ? (sum - DEPTH_W) : sum;
        return red[AW-1:0];
    endfunction

    assign offset_ok = ({1'b0, rd_offset} < DEPTH_W);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_off_d    = rd_off_q;
        loaded_d    = loaded_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_done_d   = 1'b0;
        rd_err_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        ram_raddr_d = ram_raddr_q;

        case (state_q)
            IDLE: begin
                if (frame_clr) begin
                    wr_cnt_d = '0;
                    loaded_d = 1'b0;
                end else if (in_valid && in_ready_q) begin
                    ram_waddr_d = wr_cnt_q[AW-1:0];
                    ram_wdata_d = in_data;
                    state_d     = WSETUP;
                end else if (rd_start) begin
                    if (loaded_q && offset_ok) begin
                        rd_off_d    = rd_offset;
                        rd_cnt_d    = '0;
                        ram_raddr_d = rd_offset;
                        state_d     = RSETUP;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            WSETUP: state_d = WSTRB;
            WSTRB: begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_W) begin
                    loaded_d = 1'b1;
                end
                state_d = IDLE;
            end
            RSETUP: state_d = RSTRB;
            RSTRB:  state_d = RCAP;
            RCAP: begin
                out_data_d  = ram_rdata;
                out_valid_d = 1'b1;
                state_d     = ROUT;
            end
            ROUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_cnt_q == LAST_W) begin
                        rd_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rd_cnt_d    = rd_cnt_q + 1'b1;
                        ram_raddr_d = wrap_addr(rd_off_q, rd_cnt_d[AW-1:0]);
                        state_d     = RSETUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they rise one cycle after the
        // address/data registers were loaded on entry to the setup state.
        ram_we_d   = (state_d == WSTRB);
        ram_re_d   = (state_d == RSTRB);
        in_ready_d = (state_d == IDLE) && (wr_cnt_d < DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_off_q    <= '0;
            in_ready_q  <= 1'b0;
            loaded_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_raddr_q <= '0;
            ram_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_off_q    <= rd_off_d;
            in_ready_q  <= in_ready_d;
            loaded_q    <= loaded_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rd_done_q   <= rd_done_d;
            rd_err_q    <= rd_err_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_raddr_q <= ram_raddr_d;
            ram_re_q    <= ram_re_d;
        end
    end

`ifdef DPRAM_SEQ_CTRL_PASS_CNT_EN
    logic [7:0] pass_cnt_q;
    logic       pass_clr;

    // Only a frame_clr seen in IDLE is acted upon, so only that one clears.
    assign pass_clr = (state_q == IDLE) && frame_clr;

    always_ff @(posedge clk) begin
        if (rst || pass_clr) begin
            pass_cnt_q <= 8'd0;
        end else if (rd_done_d && (pass_cnt_q != 8'hFF)) begin
            pass_cnt_q <= pass_cnt_q + 8'd1;
        end
    end

    assign pass_cnt = pass_cnt_q;
`else
    assign pass_cnt = 8'd0;
`endif

    assign in_ready  = in_ready_q;
    assign loaded    = loaded_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rd_done   = rd_done_q;
    assign rd_err    = rd_err_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_raddr = ram_raddr_q;
    assign ram_re    = ram_re_q;

endmodule

// File: tb/tb_dpram_seq_ctrl.sv
// Directed bench for dpram_seq_ctrl with a behavioural edge-triggered RAM model and an expected-row queue.
module tb_dpram_seq_ctrl;
    localparam int DW    = 24;
    localparam int AW    = 5;
    localparam int DEPTH = 27;
`ifdef DPRAM_SEQ_CTRL_PASS_CNT_EN
    localparam int PC_EN = 1;
`else
    localparam int PC_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          frame_clr;
    logic          rd_start;
    logic [AW-1:0] rd_offset;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          rd_done;
    logic          rd_err;
    logic          loaded;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_rdata = '0;
    logic [7:0]    pass_cnt;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    dpram_seq_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .frame_clr(frame_clr), .rd_start(rd_start), .rd_offset(rd_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rd_done(rd_done), .rd_err(rd_err), .loaded(loaded),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .pass_cnt(pass_cnt)
    );

    // RAM model: writes and reads happen on the rising edge of the strobes.
    logic [DW-1:0] mem [0:31];
    logic [AW-1:0] raddr_log[$];
    int            re_edges = 0;
    always @(posedge ram_we) mem[ram_waddr] <= ram_wdata;
    always @(posedge ram_re) begin
        ram_rdata <= mem[ram_raddr];
        re_edges  <= re_edges + 1;
        raddr_log.push_back(ram_raddr);
    end

    logic prev_we = 1'b0, prev_re = 1'b0, overlap_seen = 1'b0;
    always @(negedge clk) begin
        if ((ram_we && ram_re) || (ram_we && prev_re) || (ram_re && prev_we))
            overlap_seen <= 1'b1;
        prev_we <= ram_we;
        prev_re <= ram_re;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] row_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, b, b};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_data"}, out_data, 0);
        check_eq({tag, "_rd_done"}, rd_done, 0);
        check_eq({tag, "_rd_err"}, rd_err, 0);
        check_eq({tag, "_loaded"}, loaded, 0);
        check_eq({tag, "_waddr"}, ram_waddr, 0);
        check_eq({tag, "_wdata"}, ram_wdata, 0);
        check_eq({tag, "_we"}, ram_we, 0);
        check_eq({tag, "_raddr"}, ram_raddr, 0);
        check_eq({tag, "_re"}, ram_re, 0);
        check_eq({tag, "_pass_cnt"}, pass_cnt, 0);
    endtask

    // Called at a negedge while the DUT sits in IDLE; returns at the IDLE negedge after the write.
    task automatic write_row(input int idx);
        logic [DW-1:0] d;
        d = row_val(idx);
        check_eq("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("we_setup", ram_we, 0);
        check_eq("waddr_setup", ram_waddr, idx);
        check_eq("wdata_setup", ram_wdata, d);
        check_eq("in_ready_busy", in_ready, 0);
        @(negedge clk);
        check_eq("we_strb", ram_we, 1);
        check_eq("waddr_strb", ram_waddr, idx);
        check_eq("wdata_strb", ram_wdata, d);
        @(negedge clk);
        check_eq("we_done", ram_we, 0);
        check_eq("loaded_progress", loaded, (idx == DEPTH - 1) ? 1 : 0);
    endtask

    task automatic write_frame();
        for (int i = 0; i < DEPTH; i++) write_row(i);
        check_eq("in_ready_full", in_ready, 0);
    endtask

    task automatic read_pass(input int off, input int stall_row, input int stall_len, input int exp_cycles);
        int base, start_re, edges, k, stalled;
        logic done_seen;
        logic [DW-1:0] held;
        held = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(row_val((off + i) % DEPTH));
        base      = raddr_log.size();
        start_re  = re_edges;
        rd_offset = AW'(off);
        rd_start  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rd_start  = 1'b0;
        edges     = 0;
        k         = 0;
        stalled   = 0;
        done_seen = 1'b0;
        while (!done_seen && edges < 400) begin
            if (rd_done) begin
                done_seen = 1'b1;
                check_eq("rd_done_cycle", edges, exp_cycles);
            end else begin
                out_ready = !(k == stall_row && stalled < stall_len);
                if (out_valid && !out_ready) begin
                    if (stalled == 0) begin
                        held = out_data;
                        check_eq("stall_first", out_data, exp_q[0]);
                    end else begin
                        check_eq("stall_hold", out_data, held);
                    end
                    stalled++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("beat_count", k + 1, DEPTH);
                    else check_eq("out_data", out_data, exp_q.pop_front());
                    k++;
                end
                @(negedge clk);
                edges++;
            end
        end
        check_eq("rd_done_seen", done_seen, 1);
        check_eq("beats", k, DEPTH);
        if (stall_len > 0) check_eq("stall_len", stalled, stall_len);
        check_eq("re_edges", re_edges - start_re, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (base + i < raddr_log.size())
                check_eq("raddr_seq", raddr_log[base + i], (off + i) % DEPTH);
        end
        @(negedge clk);
        check_eq("rd_done_pulse", rd_done, 0);
        check_eq("out_valid_after", out_valid, 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; frame_clr = 1'b0;
        rd_start = 1'b0; rd_offset = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_reset", in_ready, 1);

        // Read request with no frame loaded
        rd_start = 1'b1; rd_offset = '0;
        @(negedge clk);
        rd_start = 1'b0;
        check_eq("rd_err_unloaded", rd_err, 1);
        @(negedge clk);
        check_eq("rd_err_pulse", rd_err, 0);
        check_eq("re_unloaded", ram_re, 0);
        check_eq("in_ready_unloaded", in_ready, 1);

        write_frame();
        in_valid = 1'b1; in_data = 24'hABCDEF;
        repeat (3) begin
            @(negedge clk);
            check_eq("we_when_full", ram_we, 0);
            check_eq("waddr_when_full", ram_waddr, DEPTH - 1);
        end
        in_valid = 1'b0;

        read_pass(0, -1, 0, 108);
        read_pass(25, -1, 0, 108);
        read_pass(0, 2, 10, 118);
        check_eq("pass_cnt_3", pass_cnt, PC_EN ? 3 : 0);
        check_eq("loaded_persist", loaded, 1);

        // Offset out of range
        rd_start = 1'b1; rd_offset = 5'd27;
        @(negedge clk);
        rd_start = 1'b0;
        check_eq("rd_err_offset", rd_err, 1);
        @(negedge clk);
        check_eq("re_bad_offset", ram_re, 0);
        check_eq("out_valid_bad_offset", out_valid, 0);

        // frame_clr wins over a simultaneous rd_start
        frame_clr = 1'b1; rd_start = 1'b1; rd_offset = '0;
        @(negedge clk);
        frame_clr = 1'b0; rd_start = 1'b0;
        check_eq("rd_err_clr", rd_err, 0);
        check_eq("loaded_clr", loaded, 0);
        check_eq("in_ready_clr", in_ready, 1);
        check_eq("pass_cnt_clr", pass_cnt, 0);
        @(negedge clk);
        check_eq("re_clr", ram_re, 0);
        check_eq("rd_err_clr2", rd_err, 0);

        write_frame();
        read_pass(3, -1, 0, 108);
        check_eq("pass_cnt_1", pass_cnt, PC_EN ? 1 : 0);

        // Reset while the read strobe is high
        rd_start = 1'b1; rd_offset = '0; out_ready = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        w = 0;
        while (ram_re !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("reach_rstrb", ram_re, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midpass_reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_post_reset", in_ready, 1);
        check_eq("loaded_post_reset", loaded, 0);
        check_eq("re_post_reset", ram_re, 0);

        check_eq("we_re_overlap", overlap_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
